// File: rtl/hilo_mdu_pkg.sv
// mdu_pkg: operation encoding, FSM states and op-decoding helpers shared by
// the HI/LO multiply/divide unit and its testbench.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   // Codes 10..15 are reserved and must be ignored.
   function automatic logic op_valid(input logic [3:0] op);
      return (op <= 4'd9);
   endfunction

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == 4'd2) || (op == 4'd3);
   endfunction

   function automatic logic op_is_mul(input logic [3:0] op);
      return (op <= 4'd7) && !op_is_div(op);
   endfunction

   // Arithmetic ops 0..7 use an even code for the signed variant.
   function automatic logic op_is_signed(input logic [3:0] op);
      return (op <= 4'd7) && !op[0];
   endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: request/response bundle between the EX stage (master) and the
// HI/LO multiply/divide unit (slave).
//   start, op, rs_i, rt_i, cancel : request side, driven by the pipeline
//   busy, done, hi_o, lo_o        : status and architectural HI/LO
interface hilo_mdu_if #(parameter int DW = 32);
   logic          start;
   logic [3:0]    op;
   logic [DW-1:0] rs_i;
   logic [DW-1:0] rt_i;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [DW-1:0] hi_o;
   logic [DW-1:0] lo_o;

   modport master (output start, op, rs_i, rt_i, cancel,
                   input  busy, done, hi_o, lo_o);
   modport slave  (input  start, op, rs_i, rt_i, cancel,
                   output busy, done, hi_o, lo_o);
endinterface

// File: rtl/hilo_div_core.sv
// hilo_div_core: iterative radix-2 restoring divider on unsigned operands.
//   load/dividend/divisor : start a new division (one quotient bit per edge)
//   kill                  : abandon the running division
//   quotient/remainder    : result of the step taken at the coming edge
//   valid                 : the coming edge performs the final step, so the
//                           owner can capture quotient/remainder on that edge
module hilo_div_core
   import mdu_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   input  logic          kill,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder,
   output logic          valid
);
   localparam int CW = $clog2(DW + 1);

   logic [DW-1:0] rem_r, quo_r, dvs_r;
   logic [CW-1:0] cnt_r;
   logic          run_r;
   logic [DW:0]   shift_s, diff_s;
   logic [DW-1:0] rem_nxt_s, quo_nxt_s;
   logic          qbit_s;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shift_s = {rem_r, quo_r[DW-1]};
      diff_s  = shift_s - {1'b0, dvs_r};
      if (!diff_s[DW]) begin
         rem_nxt_s = diff_s[DW-1:0];
         qbit_s    = 1'b1;
      end else begin
         rem_nxt_s = shift_s[DW-1:0];
         qbit_s    = 1'b0;
      end
      quo_nxt_s = {quo_r[DW-2:0], qbit_s};
   end

   assign quotient  = quo_nxt_s;
   assign remainder = rem_nxt_s;
   assign valid     = run_r && (cnt_r == CW'(1));

   // Iteration state: load, step DW times, or stop on kill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_r <= {DW{1'b0}};
         quo_r <= {DW{1'b0}};
         dvs_r <= {DW{1'b0}};
         cnt_r <= {CW{1'b0}};
         run_r <= 1'b0;
      end else if (kill) begin
         run_r <= 1'b0;
      end else if (load) begin
         rem_r <= {DW{1'b0}};
         quo_r <= dividend;
         dvs_r <= divisor;
         cnt_r <= CW'(DW);
         run_r <= 1'b1;
      end else if (run_r) begin
         rem_r <= rem_nxt_s;
         quo_r <= quo_nxt_s;
         cnt_r <= cnt_r - CW'(1);
         if (cnt_r == CW'(1)) begin
            run_r <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: architectural HI/LO registers with a multiply/accumulate and
// divide unit behind a start/busy/done handshake.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : hilo_mdu_if slave (start/op/rs_i/rt_i/cancel in,
//              busy/done/hi_o/lo_o out)
// Multiplies finish MUL_LAT edges after accept, divides DW edges after accept;
// MTHI/MTLO and divide-by-zero complete at the accept edge itself.
module hilo_mdu
   import mdu_pkg::*;
#(
   parameter int DW      = 32,
   parameter int MUL_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   hilo_mdu_if.slave    bus
);
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   mdu_state_e      state_r;
   logic [DW-1:0]   hi_r, lo_r, a_r, b_r;
   logic [3:0]      op_r;
   logic [CW-1:0]   cnt_r;
   logic            busy_r, done_r, neg_q_r, neg_rem_r;

   logic            accept_s, rs_neg_s, rt_neg_s, div_load_s, div_kill_s;
   logic [DW-1:0]   rs_mag_s, rt_mag_s, div_quo_s, div_rem_s, q_fix_s, r_fix_s;
   logic            div_valid_s;
   logic [2*DW-1:0] ext_a_s, ext_b_s, prod_s, hilo_s, mul_res_s;

   assign accept_s   = bus.start && !busy_r && !bus.cancel && op_valid(bus.op);
   assign div_load_s = accept_s && op_is_div(bus.op) && (bus.rt_i != {DW{1'b0}});
   assign div_kill_s = (state_r == ST_DIV) && bus.cancel;

   // Operand magnitudes for the divider (signed variants only).
   always_comb begin
      rs_neg_s = op_is_signed(bus.op) && bus.rs_i[DW-1];
      rt_neg_s = op_is_signed(bus.op) && bus.rt_i[DW-1];
      if (rs_neg_s) begin
         rs_mag_s = ~bus.rs_i + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         rs_mag_s = bus.rs_i;
      end
      if (rt_neg_s) begin
         rt_mag_s = ~bus.rt_i + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         rt_mag_s = bus.rt_i;
      end
   end

   hilo_div_core #(.DW(DW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load_s),
      .dividend  (rs_mag_s),
      .divisor   (rt_mag_s),
      .kill      (div_kill_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s),
      .valid     (div_valid_s)
   );

   // Full-width product and accumulate; extending to 2*DW then truncating
   // the product gives the correct signed result modulo 2^(2*DW).
   always_comb begin
      if (op_is_signed(op_r)) begin
         ext_a_s = {{DW{a_r[DW-1]}}, a_r};
         ext_b_s = {{DW{b_r[DW-1]}}, b_r};
      end else begin
         ext_a_s = {{DW{1'b0}}, a_r};
         ext_b_s = {{DW{1'b0}}, b_r};
      end
      prod_s = ext_a_s * ext_b_s;
      hilo_s = {hi_r, lo_r};
      case (op_r)
         OP_MADD, OP_MADDU: mul_res_s = hilo_s + prod_s;
         OP_MSUB, OP_MSUBU: mul_res_s = hilo_s - prod_s;
         default:           mul_res_s = prod_s;
      endcase
   end

   // Sign fix-up of the unsigned divider result. The -2^(DW-1)/-1 case needs
   // no special handling: magnitude 2^(DW-1) is already the required pattern.
   always_comb begin
      if (neg_q_r) begin
         q_fix_s = ~div_quo_s + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         q_fix_s = div_quo_s;
      end
      if (neg_rem_r) begin
         r_fix_s = ~div_rem_s + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         r_fix_s = div_rem_s;
      end
   end

   // Control FSM, HI/LO registers and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         hi_r      <= {DW{1'b0}};
         lo_r      <= {DW{1'b0}};
         a_r       <= {DW{1'b0}};
         b_r       <= {DW{1'b0}};
         op_r      <= 4'd0;
         cnt_r     <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (bus.op == OP_MTHI) begin
                     hi_r   <= bus.rs_i;
                     done_r <= 1'b1;
                  end else if (bus.op == OP_MTLO) begin
                     lo_r   <= bus.rs_i;
                     done_r <= 1'b1;
                  end else if (op_is_div(bus.op)) begin
                     if (bus.rt_i == {DW{1'b0}}) begin
                        lo_r   <= {DW{1'b1}};
                        hi_r   <= bus.rs_i;
                        done_r <= 1'b1;
                     end else begin
                        state_r   <= ST_DIV;
                        busy_r    <= 1'b1;
                        neg_q_r   <= rs_neg_s ^ rt_neg_s;
                        neg_rem_r <= rs_neg_s;
                     end
                  end else begin
                     a_r     <= bus.rs_i;
                     b_r     <= bus.rt_i;
                     op_r    <= bus.op;
                     cnt_r   <= CW'(MUL_LAT - 1);
                     state_r <= ST_MUL;
                     busy_r  <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               if (bus.cancel) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (cnt_r == {CW{1'b0}}) begin
                  {hi_r, lo_r} <= mul_res_s;
                  state_r      <= ST_IDLE;
                  busy_r       <= 1'b0;
                  done_r       <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            ST_DIV: begin
               if (bus.cancel) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else if (div_valid_s) begin
                  lo_r    <= q_fix_s;
                  hi_r    <= r_fix_s;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi_o = hi_r;
   assign bus.lo_o = lo_r;
endmodule
